// File: rtl/sysid_pkg.sv
// sysid_pkg: address map, sequencer states and error-flag bit positions shared by the sysid checker
package sysid_pkg;
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;
  localparam int ERR_ID = 0;
  localparam int ERR_TS = 1;
  localparam int ERR_TO = 2;
  typedef enum logic [2:0] {S_IDLE, S_RD_ID, S_LAT_ID, S_RD_TS, S_LAT_TS, S_FINISH} state_t;
endpackage

// File: rtl/avmm_read_engine.sv
// avmm_read_engine: single Avalon-MM read with waitrequest hold, fixed-latency capture and stall timeout
module avmm_read_engine #(
  parameter int READ_LATENCY = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic req,
  input  logic addr,
  input  logic av_waitrequest,
  output logic av_read,
  output logic av_address,
  output logic accept,
  output logic cap,
  output logic fin,
  output logic tmo
);
  localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY == 0 ? 0 : READ_LATENCY - 1);
  localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic rd_q, rd_d, lat_q, lat_d, addr_q, addr_d, last_lat;
  logic [1:0] lat_cnt_q, lat_cnt_d;
  logic [15:0] stall_q, stall_d;
  always_comb begin
    accept = rd_q & ~av_waitrequest;
    tmo = rd_q & av_waitrequest & (stall_q == STALL_LAST);
    last_lat = lat_q & (lat_cnt_q == LAT_LAST);
    cap = (READ_LATENCY == 0) ? accept : last_lat;
    fin = last_lat | tmo;
    rd_d = req | (rd_q & ~accept & ~tmo);
    lat_d = accept | (lat_q & ~last_lat);
    lat_cnt_d = (lat_q & ~last_lat) ? lat_cnt_q + 2'd1 : 2'd0;
    stall_d = (rd_q & av_waitrequest & ~req) ? stall_q + 16'd1 : 16'd0;
    addr_d = req ? addr : addr_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q <= 1'b0;
      lat_q <= 1'b0;
      addr_q <= 1'b0;
      lat_cnt_q <= 2'd0;
      stall_q <= 16'd0;
    end else begin
      rd_q <= rd_d;
      lat_q <= lat_d;
      addr_q <= addr_d;
      lat_cnt_q <= lat_cnt_d;
      stall_q <= stall_d;
    end
  end
  assign av_read = rd_q;
  assign av_address = addr_q;
endmodule

// File: rtl/sysid_checker.sv
// sysid_checker: reads the sysid ID and timestamp words, compares them to build constants and reports pass/fail
module sysid_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXP_ID = 32'd11,
  parameter logic [31:0] EXP_TS = 32'd1447854940,
  parameter int READ_LATENCY = 0,
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit AUTO_START = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        av_address,
  output logic        av_read,
  input  logic        av_waitrequest,
  input  logic [31:0] av_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [2:0]  err_flags
);
  state_t state_q, state_d;
  logic first_q, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic id_ok_q, id_ok_d, ts_ok_q, ts_ok_d;
  logic [31:0] id_q, id_d, ts_q, ts_d;
  logic [2:0] err_q, err_d;
  logic req, req_addr, accept, cap, fin, tmo;
  avmm_read_engine #(.READ_LATENCY(READ_LATENCY), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_eng (
    .clock(clock),
    .reset(reset),
    .req(req),
    .addr(req_addr),
    .av_waitrequest(av_waitrequest),
    .av_read(av_read),
    .av_address(av_address),
    .accept(accept),
    .cap(cap),
    .fin(fin),
    .tmo(tmo)
  );
  always_comb begin
    state_d = state_q;
    busy_d = busy_q;
    done_d = 1'b0;
    pass_d = pass_q;
    err_d = err_q;
    id_ok_d = id_ok_q;
    ts_ok_d = ts_ok_q;
    id_d = (cap & (av_address == SYSID_ADDR_ID)) ? av_readdata : id_q;
    ts_d = (cap & (av_address == SYSID_ADDR_TS)) ? av_readdata : ts_q;
    req = 1'b0;
    req_addr = SYSID_ADDR_ID;
    case (state_q)
      S_IDLE: if (start | first_q) begin
        state_d = S_RD_ID;
        busy_d = 1'b1;
        pass_d = 1'b0;
        err_d = 3'b000;
        id_ok_d = 1'b0;
        ts_ok_d = 1'b0;
        req = 1'b1;
      end
      S_RD_ID, S_RD_TS: state_d = tmo ? S_FINISH : accept ? ((state_q == S_RD_ID) ? S_LAT_ID : S_LAT_TS) : state_q;
      S_LAT_ID: if (fin) begin
        state_d = S_RD_TS;
        id_ok_d = 1'b1;
        req = 1'b1;
        req_addr = SYSID_ADDR_TS;
      end
      S_LAT_TS: if (fin) begin
        state_d = S_FINISH;
        ts_ok_d = 1'b1;
      end
      S_FINISH: begin
        state_d = S_IDLE;
        busy_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_FINISH && state_q != S_FINISH) begin
      done_d = 1'b1;
      err_d[ERR_TO] = tmo;
      err_d[ERR_ID] = id_ok_d & (id_d != EXP_ID);
      err_d[ERR_TS] = ts_ok_d & (ts_d != EXP_TS);
      pass_d = id_ok_d & ts_ok_d & ~tmo & (id_d == EXP_ID) & (ts_d == EXP_TS);
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      first_q <= AUTO_START;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      err_q <= 3'b000;
      id_ok_q <= 1'b0;
      ts_ok_q <= 1'b0;
      id_q <= 32'd0;
      ts_q <= 32'd0;
    end else begin
      state_q <= state_d;
      first_q <= 1'b0;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
      err_q <= err_d;
      id_ok_q <= id_ok_d;
      ts_ok_q <= ts_ok_d;
      id_q <= id_d;
      ts_q <= ts_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign pass = pass_q;
  assign err_flags = err_q;
  assign id_value = id_q;
  assign ts_value = ts_q;
endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker: two checker instances (latency 0 auto-start, latency 2 manual) against behavioural sysid responders
module tb_sysid_checker;
  localparam int T = 8;
  localparam logic [31:0] EXP_ID = 32'd11;
  localparam logic [31:0] EXP_TS = 32'd1447854940;
  typedef struct {
    int off;
    logic [2:0] err;
    logic pass;
    logic [31:0] id;
    logic [31:0] ts;
    int reads;
    int ts_reads;
  } exp_t;
  logic clock = 1'b0;
  logic [1:0] rst = 2'b11;
  logic [1:0] start = 2'b00;
  logic [1:0] av_read, av_address, av_wait, busy, done, pass;
  logic [31:0] rdata [2];
  logic [31:0] id_value [2];
  logic [31:0] ts_value [2];
  logic [2:0] err [2];
  int wlim [2][2];
  logic [31:0] word [2][2];
  int stall_cnt [2] = '{0, 0};
  logic [31:0] junk = 32'hdeadbeef;
  logic [1:0] pv = 2'b00;
  logic [1:0] pa = 2'b00;
  int cyc = 0;
  int done_cnt [2], done_cyc [2], reads [2], ts_reads [2], hold_err [2], b2b_err [2];
  logic [1:0] prev_wait = 2'b00, prev_addr = 2'b00, prev_acc = 2'b00;
  logic [31:0] mid [2] = '{32'd0, 32'd0};
  logic [31:0] mts [2] = '{32'd0, 32'd0};
  int checks = 0, passed = 0;

  always #5 clock = ~clock;

  sysid_checker #(.READ_LATENCY(0), .TIMEOUT_CYCLES(T), .AUTO_START(1'b1)) dut_a (
    .clock(clock), .reset(rst[0]), .start(start[0]), .av_address(av_address[0]), .av_read(av_read[0]),
    .av_waitrequest(av_wait[0]), .av_readdata(rdata[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .id_value(id_value[0]), .ts_value(ts_value[0]), .err_flags(err[0]));
  sysid_checker #(.READ_LATENCY(2), .TIMEOUT_CYCLES(T), .AUTO_START(1'b0)) dut_b (
    .clock(clock), .reset(rst[1]), .start(start[1]), .av_address(av_address[1]), .av_read(av_read[1]),
    .av_waitrequest(av_wait[1]), .av_readdata(rdata[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .id_value(id_value[1]), .ts_value(ts_value[1]), .err_flags(err[1]));

  // responders: each read stalls wlim cycles, then data appears 0 (inst a) or 2 (inst b) cycles after accept
  always_comb begin
    for (int k = 0; k < 2; k++) av_wait[k] = av_read[k] && (stall_cnt[k] < wlim[k][av_address[k]]);
    rdata[0] = (av_read[0] && !av_wait[0]) ? word[0][av_address[0]] : junk;
    rdata[1] = pv[1] ? word[1][pa[1]] : junk;
  end

  always @(posedge clock) begin
    cyc <= cyc + 1;
    junk <= $urandom;
    for (int k = 0; k < 2; k++) stall_cnt[k] <= (av_read[k] && av_wait[k]) ? stall_cnt[k] + 1 : 0;
    pv <= {pv[0], av_read[1] && !av_wait[1]};
    pa <= {pa[0], av_address[1]};
  end

  always @(posedge clock) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      if (done[k]) begin
        done_cnt[k]++;
        done_cyc[k] = cyc;
      end
      if (av_read[k]) reads[k]++;
      if (av_read[k] && av_address[k]) ts_reads[k]++;
      if (prev_wait[k] && av_read[k] && av_address[k] != prev_addr[k]) hold_err[k]++;
      if (prev_acc[k] && av_read[k]) b2b_err[k]++;
      prev_wait[k] = av_read[k] && av_wait[k];
      prev_addr[k] = av_address[k];
      prev_acc[k] = av_read[k] && !av_wait[k];
    end
  end

  function automatic exp_t model(int lat, int wi, int wt, logic [31:0] di, logic [31:0] dt, logic [31:0] pi, logic [31:0] pt);
    exp_t e;
    int m, r2;
    m = (lat == 0) ? 1 : lat;
    e.id = pi;
    e.ts = pt;
    e.pass = 1'b0;
    e.ts_reads = 0;
    if (wi >= T) begin
      e.err = 3'b100;
      e.off = 1 + T;
      e.reads = T;
      return e;
    end
    e.id = di;
    r2 = 1 + wi + m + 1;
    if (wt >= T) begin
      e.err = {2'b10, di != EXP_ID};
      e.off = r2 + T;
      e.reads = wi + 1 + T;
      e.ts_reads = T;
      return e;
    end
    e.ts = dt;
    e.err = {1'b0, dt != EXP_TS, di != EXP_ID};
    e.pass = (e.err == 3'b000);
    e.off = r2 + wt + m + 1;
    e.reads = wi + wt + 2;
    e.ts_reads = wt + 1;
    return e;
  endfunction

  task automatic setup(input int k, input int wi, input int wt, input logic [31:0] di, input logic [31:0] dt);
    wlim[k][0] = wi;
    wlim[k][1] = wt;
    word[k][0] = di;
    word[k][1] = dt;
  endtask

  task automatic clear(input int k);
    done_cnt[k] = 0;
    reads[k] = 0;
    ts_reads[k] = 0;
    hold_err[k] = 0;
    b2b_err[k] = 0;
  endtask

  task automatic pulse(input int k, output int g);
    @(negedge clock);
    clear(k);
    g = cyc;
    start[k] = 1'b1;
    @(negedge clock);
    start[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, output bit got);
    for (int i = 0; i < 100 && done_cnt[k] == 0; i++) @(negedge clock);
    got = (done_cnt[k] != 0);
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset;
    setup(0, 0, 0, EXP_ID, EXP_TS);
    setup(1, 0, 0, EXP_ID, EXP_TS);
    repeat (3) @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      checks++; if ({av_read[k], av_address[k], busy[k], done[k], pass[k], err[k]} !== 8'd0) $display("FAIL reset_ctl[%0d]: got %b want 0", k, {av_read[k], av_address[k], busy[k], done[k], pass[k], err[k]}); else passed++;
      checks++; if (id_value[k] !== 32'd0) $display("FAIL reset_id[%0d]: got %0h want 0", k, id_value[k]); else passed++;
      checks++; if (ts_value[k] !== 32'd0) $display("FAIL reset_ts[%0d]: got %0h want 0", k, ts_value[k]); else passed++;
    end
    rst[1] = 1'b0;
  endtask

  task automatic test_auto_pass;
    bit got;
    int g;
    @(negedge clock);
    clear(0);
    g = cyc;
    rst[0] = 1'b0;
    wait_done(0, got);
    checks++; if (!got) $display("FAIL auto_done: got no done want done"); else passed++;
    checks++; if (done_cyc[0] !== g + 5) $display("FAIL auto_done_cycle: got %0d want %0d", done_cyc[0] - g, 5); else passed++;
    checks++; if (reads[0] !== 2 || b2b_err[0] !== 0) $display("FAIL auto_reads: got %0d reads %0d back-to-back want 2/0", reads[0], b2b_err[0]); else passed++;
    checks++; if ({pass[0], err[0]} !== 4'b1000) $display("FAIL auto_result: got pass=%b err=%b want 1/000", pass[0], err[0]); else passed++;
    checks++; if (id_value[0] !== EXP_ID || ts_value[0] !== EXP_TS) $display("FAIL auto_values: got %0d/%0d", id_value[0], ts_value[0]); else passed++;
    checks++; if (busy[0] !== 1'b0) $display("FAIL auto_idle_busy: got %b want 0", busy[0]); else passed++;
    mid[0] = EXP_ID;
    mts[0] = EXP_TS;
  endtask

  task automatic test_id_mismatch;
    bit got;
    int g;
    setup(0, 0, 0, 32'd12, EXP_TS);
    pulse(0, g);
    wait_done(0, got);
    checks++; if (!got || done_cyc[0] !== g + 5) $display("FAIL idmis_done: got %0b at %0d want done at 5", got, done_cyc[0] - g); else passed++;
    checks++; if ({pass[0], err[0]} !== 4'b0001) $display("FAIL idmis_result: got pass=%b err=%b want 0/001", pass[0], err[0]); else passed++;
    checks++; if (id_value[0] !== 32'd12) $display("FAIL idmis_id: got %0d want 12", id_value[0]); else passed++;
    checks++; if (ts_reads[0] !== 1) $display("FAIL idmis_ts_read: got %0d want 1", ts_reads[0]); else passed++;
    mid[0] = 32'd12;
  endtask

  task automatic test_wait_latency;
    bit got;
    int g;
    setup(1, 3, 3, EXP_ID, EXP_TS);
    pulse(1, g);
    wait_done(1, got);
    checks++; if (!got || done_cyc[1] !== g + 13) $display("FAIL wl_done: got %0b at %0d want done at 13", got, done_cyc[1] - g); else passed++;
    checks++; if (hold_err[1] !== 0 || b2b_err[1] !== 0 || reads[1] !== 8) $display("FAIL wl_bus: got hold=%0d b2b=%0d reads=%0d want 0/0/8", hold_err[1], b2b_err[1], reads[1]); else passed++;
    checks++; if ({pass[1], err[1]} !== 4'b1000) $display("FAIL wl_result: got pass=%b err=%b want 1/000", pass[1], err[1]); else passed++;
    checks++; if (id_value[1] !== EXP_ID || ts_value[1] !== EXP_TS) $display("FAIL wl_values: got %0h/%0h", id_value[1], ts_value[1]); else passed++;
    mid[1] = EXP_ID;
    mts[1] = EXP_TS;
  endtask

  task automatic test_timeout;
    bit got;
    int g;
    setup(0, 1000, 0, EXP_ID, EXP_TS);
    pulse(0, g);
    wait_done(0, got);
    checks++; if (!got || done_cyc[0] !== g + 1 + T) $display("FAIL to_done: got %0b at %0d want done at %0d", got, done_cyc[0] - g, 1 + T); else passed++;
    checks++; if ({pass[0], err[0]} !== 4'b0100) $display("FAIL to_result: got pass=%b err=%b want 0/100", pass[0], err[0]); else passed++;
    checks++; if (reads[0] !== T || ts_reads[0] !== 0) $display("FAIL to_reads: got %0d/%0d want %0d/0", reads[0], ts_reads[0], T); else passed++;
    checks++; if (id_value[0] !== mid[0] || ts_value[0] !== mts[0]) $display("FAIL to_kept: got %0h/%0h want %0h/%0h", id_value[0], ts_value[0], mid[0], mts[0]); else passed++;
  endtask

  task automatic test_busy_start_and_reset;
    int g;
    setup(1, 0, 0, EXP_ID, EXP_TS);
    pulse(1, g);
    start[1] = 1'b1;
    @(negedge clock);
    start[1] = 1'b0;
    repeat (5) @(negedge clock);
    start[1] = 1'b1;
    @(negedge clock);
    start[1] = 1'b0;
    repeat (10) @(negedge clock);
    checks++; if (done_cnt[1] !== 1 || done_cyc[1] !== g + 7) $display("FAIL ignore_start: got %0d dones last at %0d want 1 at 7", done_cnt[1], done_cyc[1] - g); else passed++;
    checks++; if (busy[1] !== 1'b0 || pass[1] !== 1'b1) $display("FAIL ignore_state: got busy=%b pass=%b want 0/1", busy[1], pass[1]); else passed++;
    pulse(1, g);
    repeat (4) @(negedge clock);
    rst[1] = 1'b1;
    @(negedge clock);
    checks++; if ({av_read[1], av_address[1], busy[1], done[1], pass[1], err[1]} !== 8'd0) $display("FAIL midreset_ctl: got %b want 0", {av_read[1], av_address[1], busy[1], done[1], pass[1], err[1]}); else passed++;
    checks++; if (id_value[1] !== 32'd0 || ts_value[1] !== 32'd0) $display("FAIL midreset_values: got %0h/%0h want 0/0", id_value[1], ts_value[1]); else passed++;
    rst[1] = 1'b0;
    repeat (10) @(negedge clock);
    checks++; if (done_cnt[1] !== 0 || ts_value[1] !== 32'd0) $display("FAIL midreset_after: got %0d dones ts=%0h want 0/0", done_cnt[1], ts_value[1]); else passed++;
    mid[1] = 32'd0;
    mts[1] = 32'd0;
  endtask

  task automatic test_manual_restart;
    bit got;
    int g;
    setup(1, 0, 0, EXP_ID, 32'h1234);
    pulse(1, g);
    wait_done(1, got);
    checks++; if (!got || err[1] !== 3'b010 || pass[1] !== 1'b0) $display("FAIL restart_fail: got err=%b pass=%b want 010/0", err[1], pass[1]); else passed++;
    setup(1, 0, 0, EXP_ID, EXP_TS);
    pulse(1, g);
    checks++; if (err[1] !== 3'b000 || busy[1] !== 1'b1) $display("FAIL restart_clear: got err=%b busy=%b want 000/1", err[1], busy[1]); else passed++;
    wait_done(1, got);
    checks++; if (!got || pass[1] !== 1'b1 || err[1] !== 3'b000) $display("FAIL restart_pass: got pass=%b err=%b want 1/000", pass[1], err[1]); else passed++;
    mid[1] = EXP_ID;
    mts[1] = EXP_TS;
  endtask

  task automatic test_random;
    exp_t e;
    bit got;
    int g, k, wi, wt;
    logic [31:0] di, dt;
    for (int i = 0; i < 24; i++) begin
      k = i % 2;
      wi = $urandom_range(0, 9);
      wt = $urandom_range(0, 9);
      di = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
      dt = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
      setup(k, wi, wt, di, dt);
      e = model(k == 0 ? 0 : 2, wi, wt, di, dt, mid[k], mts[k]);
      pulse(k, g);
      wait_done(k, got);
      checks++; if (!got || done_cnt[k] !== 1 || done_cyc[k] !== g + e.off) $display("FAIL rnd%0d_done: got %0d dones at %0d want 1 at %0d", i, done_cnt[k], done_cyc[k] - g, e.off); else passed++;
      checks++; if (err[k] !== e.err || pass[k] !== e.pass) $display("FAIL rnd%0d_result: got err=%b pass=%b want %b/%b", i, err[k], pass[k], e.err, e.pass); else passed++;
      checks++; if (id_value[k] !== e.id || ts_value[k] !== e.ts) $display("FAIL rnd%0d_values: got %0h/%0h want %0h/%0h", i, id_value[k], ts_value[k], e.id, e.ts); else passed++;
      checks++; if (reads[k] !== e.reads || ts_reads[k] !== e.ts_reads) $display("FAIL rnd%0d_reads: got %0d/%0d want %0d/%0d", i, reads[k], ts_reads[k], e.reads, e.ts_reads); else passed++;
      checks++; if (hold_err[k] !== 0 || b2b_err[k] !== 0) $display("FAIL rnd%0d_bus: got hold=%0d b2b=%0d want 0/0", i, hold_err[k], b2b_err[k]); else passed++;
      mid[k] = e.id;
      mts[k] = e.ts;
    end
  endtask

  initial begin
    test_reset;
    test_auto_pass;
    test_id_mismatch;
    test_wait_latency;
    test_timeout;
    test_busy_start_and_reset;
    test_manual_restart;
    test_random;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
